// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the shared pseudo-random source and its arbiter:
// source width, feedback taps, lockup/reset values, FSM encoding, and the
// helpers that step and sanitise the source register.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W      = 8;
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;

    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 8'hFF;
    localparam logic [LFSR_W-1:0] LFSR_RESET  = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEED  = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    // XNOR feedback: all-zeros is a legal state, all-ones is the lockup state.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ~(s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO])};
    endfunction

    // A lockup seed would freeze the sequence; substitute the reset value.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
        return (s == LFSR_LOCKUP) ? LFSR_RESET : s;
    endfunction

endpackage

// File: rtl/lfsr_rand_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request at or after i_ptr,
// searching cyclically.
//   i_req  [NUM_REQ]  level requests
//   i_ptr  [IDX_W]    highest-priority index this cycle (must be < NUM_REQ)
//   o_gnt  [NUM_REQ]  one-hot winner (zero when no request)
//   o_idx  [IDX_W]    winner index
//   o_any             at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0] w_k;
    logic           w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Candidate index ptr+i, folded back into 0..NUM_REQ-1.
            w_k = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_k >= (IDX_W+1)'(NUM_REQ))
                w_k = w_k - (IDX_W+1)'(NUM_REQ);
            if (!w_found && i_req[w_k[IDX_W-1:0]]) begin
                w_found                 = 1'b1;
                o_gnt[w_k[IDX_W-1:0]] = 1'b1;
                o_idx                   = w_k[IDX_W-1:0];
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_rand_arbiter
// One 8-bit XNOR LFSR shared by NUM_REQ traffic generators. Each cycle one
// requester is granted round-robin and receives the current random value plus
// an inject flag (value < cfg_rate); the LFSR then advances one step. The LFSR
// only moves on an issued grant, so the sequence seen across all ports is
// reproducible from the seed.
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_cfg_seed_load        strobe: load i_cfg_seed (wins over arbitration)
//   i_cfg_seed  [8]        seed (8'hFF is loaded as 8'h00)
//   i_cfg_rate  [8]        inject threshold, sampled at the arbitration edge
//   i_req       [NUM_REQ]  level requests
//   o_gnt       [NUM_REQ]  registered one-hot grant
//   o_rnd_valid            grant present this cycle
//   o_rnd_data  [8]        random value delivered with the grant (held when idle)
//   o_rnd_inject           inject decision delivered with the grant (held when idle)
//   o_grant_cnt [16]       wrapping count of grants issued
// -----------------------------------------------------------------------------
module lfsr_rand_arbiter
    import lfsr_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cfg_seed_load,
    input  logic [LFSR_W-1:0]   i_cfg_seed,
    input  logic [LFSR_W-1:0]   i_cfg_rate,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic                o_rnd_valid,
    output logic [LFSR_W-1:0]   o_rnd_data,
    output logic                o_rnd_inject,
    output logic [15:0]         o_grant_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              r_state,      w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr,       w_lfsr_nxt;
    logic [IDX_W-1:0]    r_ptr,        w_ptr_nxt;
    logic [NUM_REQ-1:0]  r_gnt,        w_gnt_nxt;
    logic [LFSR_W-1:0]   r_rnd_data,   w_rnd_data_nxt;
    logic                r_rnd_inject, w_rnd_inject_nxt;
    logic [15:0]         r_grant_cnt,  w_grant_cnt_nxt;

    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Every transition is decided from inputs alone; the state register
    // records which action was taken so outputs can be decoded from it.
    always_comb begin
        w_state_nxt      = S_IDLE;
        w_lfsr_nxt       = r_lfsr;
        w_ptr_nxt        = r_ptr;
        w_gnt_nxt        = '0;
        w_rnd_data_nxt   = r_rnd_data;
        w_rnd_inject_nxt = r_rnd_inject;
        w_grant_cnt_nxt  = r_grant_cnt;

        if (i_cfg_seed_load) begin
            w_state_nxt = S_SEED;
            w_lfsr_nxt  = lfsr_seed_fix(i_cfg_seed);
        end else if (w_arb_any) begin
            w_state_nxt      = S_GRANT;
            w_gnt_nxt        = w_arb_gnt;
            w_rnd_data_nxt   = r_lfsr;
            w_rnd_inject_nxt = (r_lfsr < i_cfg_rate);
            w_lfsr_nxt       = lfsr_step(r_lfsr);
            w_ptr_nxt        = (w_arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_arb_idx + 1'b1;
            w_grant_cnt_nxt  = r_grant_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_RESET;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_rnd_data   <= LFSR_RESET;
            r_rnd_inject <= 1'b0;
            r_grant_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rnd_data   <= w_rnd_data_nxt;
            r_rnd_inject <= w_rnd_inject_nxt;
            r_grant_cnt  <= w_grant_cnt_nxt;
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rnd_valid  = (r_state == S_GRANT);
    assign o_rnd_data   = r_rnd_data;
    assign o_rnd_inject = r_rnd_inject;
    assign o_grant_cnt  = r_grant_cnt;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rand_arbiter
// Directed bench for lfsr_rand_arbiter (NUM_REQ=4). Inputs change 1ns after
// the rising edge; outputs are checked at that same point, so each check sees
// the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_lfsr_rand_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [7:0]  seed;
    logic [7:0]  rate;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        rnd_valid;
    logic [7:0]  rnd_data;
    logic        rnd_inject;
    logic [15:0] grant_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_rand_arbiter #(.NUM_REQ(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cfg_seed_load (seed_load),
        .i_cfg_seed      (seed),
        .i_cfg_rate      (rate),
        .i_req           (req),
        .o_gnt           (gnt),
        .o_rnd_valid     (rnd_valid),
        .o_rnd_data      (rnd_data),
        .o_rnd_inject    (rnd_inject),
        .o_grant_cnt     (grant_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot in one call.
    task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic e_vld,
                           input logic [7:0] e_data, input logic e_inj, input logic [15:0] e_cnt);
        chk({tag, ".gnt"},  {28'd0, gnt},        {28'd0, e_gnt});
        chk({tag, ".vld"},  {31'd0, rnd_valid},  {31'd0, e_vld});
        chk({tag, ".data"}, {24'd0, rnd_data},   {24'd0, e_data});
        chk({tag, ".inj"},  {31'd0, rnd_inject}, {31'd0, e_inj});
        chk({tag, ".cnt"},  {16'd0, grant_cnt},  {16'd0, e_cnt});
    endtask

    initial begin
        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        rate      = 8'h00;
        req       = 4'hF;

        // Reset held 3 cycles with all requests up.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
        end
        rst_n = 1'b1;
        tick();
        // rate=0 never injects, even for value 00.
        chk_all("first_grant", 4'b0001, 1'b1, 8'h00, 1'b0, 16'd1);

        // Re-reset so the sequence test starts from 00.
        rst_n = 1'b0; req = 4'b0000;
        tick();
        chk_all("rereset1", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
        rst_n = 1'b1;

        // Sequence with req[0] held, rate=05.
        req = 4'b0001; rate = 8'h05;
        tick(); chk_all("seq0", 4'b0001, 1'b1, 8'h00, 1'b1, 16'd1);
        tick(); chk_all("seq1", 4'b0001, 1'b1, 8'h01, 1'b1, 16'd2);
        tick(); chk_all("seq2", 4'b0001, 1'b1, 8'h03, 1'b1, 16'd3);
        tick(); chk_all("seq3", 4'b0001, 1'b1, 8'h07, 1'b0, 16'd4);
        tick(); chk_all("seq4", 4'b0001, 1'b1, 8'h0E, 1'b0, 16'd5);

        // Round-robin from a clean pointer.
        rst_n = 1'b0; req = 4'b0000;
        tick();
        chk_all("rereset2", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
        rst_n = 1'b1; rate = 8'h00;
        req = 4'hF;
        tick(); chk_all("rr0", 4'b0001, 1'b1, 8'h00, 1'b0, 16'd1);
        tick(); chk_all("rr1", 4'b0010, 1'b1, 8'h01, 1'b0, 16'd2);
        tick(); chk_all("rr2", 4'b0100, 1'b1, 8'h03, 1'b0, 16'd3);
        tick(); chk_all("rr3", 4'b1000, 1'b1, 8'h07, 1'b0, 16'd4);
        tick(); chk_all("rr4", 4'b0001, 1'b1, 8'h0E, 1'b0, 16'd5);
        req = 4'b1101;
        tick(); chk_all("rr_skip1", 4'b0100, 1'b1, 8'h1C, 1'b0, 16'd6);
        // Idle: valid drops, data/inject hold.
        req = 4'b0000;
        tick(); chk_all("idle_hold", 4'b0000, 1'b0, 8'h1C, 1'b0, 16'd6);

        // Seed load wins over a simultaneous request; lfsr was 39 before.
        seed = 8'h1C; seed_load = 1'b1; req = 4'b0100; rate = 8'h20;
        tick(); chk_all("seed_nogrant", 4'b0000, 1'b0, 8'h1C, 1'b0, 16'd6);
        seed_load = 1'b0;
        tick(); chk_all("seed_g0", 4'b0100, 1'b1, 8'h1C, 1'b1, 16'd7);
        tick(); chk_all("seed_g1", 4'b0100, 1'b1, 8'h39, 1'b0, 16'd8);

        // Lockup guard: FF seeds as 00; rate=FF always injects.
        req = 4'b0000; seed = 8'hFF; seed_load = 1'b1; rate = 8'hFF;
        tick(); chk_all("ff_seed", 4'b0000, 1'b0, 8'h39, 1'b0, 16'd8);
        seed_load = 1'b0; req = 4'b0001;
        tick(); chk_all("ff_g0", 4'b0001, 1'b1, 8'h00, 1'b1, 16'd9);
        tick(); chk_all("ff_g1", 4'b0001, 1'b1, 8'h01, 1'b1, 16'd10);

        // Counter wrap: 65536 back-to-back grants from zero.
        rst_n = 1'b0; req = 4'b0000;
        tick();
        chk("rereset3.cnt", {16'd0, grant_cnt}, 32'd0);
        rst_n = 1'b1; req = 4'hF;
        for (int i = 0; i < 65535; i++) tick();
        chk("cnt_ffff", {16'd0, grant_cnt}, 32'h0000FFFF);
        chk("cnt_ffff.vld", {31'd0, rnd_valid}, 32'd1);
        tick();
        chk("cnt_wrap", {16'd0, grant_cnt}, 32'd0);

        // Reset mid-burst: in-flight grant is dropped on that edge.
        rst_n = 1'b0;
        tick(); chk_all("mid_reset", 4'b0000, 1'b0, 8'h00, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick(); chk_all("post_reset", 4'b0001, 1'b1, 8'h00, 1'b1, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_arbiter.md
# lfsr_rand_arbiter

Shares one 8-bit XNOR-feedback pseudo-random source among NUM_REQ mesh traffic-generator ports, so every node draws from one reproducible sequence. Round-robin arbitration grants one requester per cycle. The winner receives the current random value plus an inject decision from a programmable rate threshold, and the source then advances by exactly one step. The block sits between the per-router packet generators and the random source; it owns seeding, sequencing and arbitration of that source.

## Interface
- NUM_REQ, 4, number of requesting generator ports (2..8)
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_seed_load  in  1  one-cycle strobe: load cfg_seed into the source
- cfg_seed  in  8  seed value
- cfg_rate  in  8  inject threshold; inject when random value < cfg_rate
- req  in  NUM_REQ  level request, one bit per port
- gnt  out  NUM_REQ  one-hot grant, registered
- rnd_valid  out  1  high in any cycle where gnt is non-zero
- rnd_data  out  8  random value delivered with gnt
- rnd_inject  out  1  (rnd_data < cfg_rate), sampled in the arbitration cycle
- grant_cnt  out  16  total grants issued, wraps at 16'hFFFF -> 0

## Operation
- The source register lfsr[7:0] steps as lfsr <= {lfsr[6:0], ~(lfsr[4] ^ lfsr[2])}.
- The source steps only on an issued grant; it is never free-running.
- The lockup state for this feedback is 8'hFF. A seed of 8'hFF is loaded as 8'h00, so lfsr never holds 8'hFF.
- Reset sequence from 8'h00: 00, 01, 03, 07, 0E, 1C, 39, ...
- FSM states: S_IDLE, S_SEED, S_GRANT. State is registered; outputs are driven by registers written on the same edge.
  - Any state, cfg_seed_load=1 -> S_SEED: lfsr <= sanitized cfg_seed; no grant on the next cycle.
  - Any state, cfg_seed_load=0 and |req -> S_GRANT: winner = first set req bit at or after rr_ptr (cyclic). gnt <= onehot(winner), rnd_data <= lfsr, rnd_inject <= (lfsr < cfg_rate), lfsr <= step(lfsr), rr_ptr <= winner+1 mod NUM_REQ, grant_cnt += 1.
  - Any state, otherwise -> S_IDLE: gnt <= 0, rnd_valid <= 0. rnd_data and rnd_inject hold their last values.
- Seed load takes priority over arbitration in the same cycle. Pending requests are served on the following cycle.
- The requester must drop req in the cycle gnt is visible. A req still high in that cycle counts as a new request, which allows back-to-back grants.
- cfg_rate=0 never injects. cfg_rate=8'hFF always injects, because lfsr is never 8'hFF.
- Reset values: state S_IDLE, lfsr 8'h00, rr_ptr 0, gnt 0, rnd_valid 0, rnd_data 8'h00, rnd_inject 0, grant_cnt 0. A reset mid-grant clears all of these on that edge; the grant in flight is dropped.

## Timing
- Latency: req sampled at edge N -> gnt, rnd_valid, rnd_data and rnd_inject valid for the whole of cycle N+1.
- Throughput: one grant per cycle under continuous requests.
- Seed strobe at edge N -> the grant decided at edge N+1 delivers the seed value (8'h00 if the seed was 8'hFF).
- cfg_rate is sampled at the arbitration edge only.
- grant_cnt updates on the same edge as gnt.

## Structure
- Package lfsr_pkg holds:
  - LFSR_W=8
  - tap indices 4 and 2
  - LFSR_LOCKUP=8'hFF
  - LFSR_RESET=8'h00
  - state encoding for S_IDLE, S_SEED and S_GRANT
  - function lfsr_step()
- One sub-module, rr_arbiter: combinational req + rr_ptr -> one-hot winner and index, parameterised by NUM_REQ.
- The top level holds the FSM, the lfsr, rr_ptr, the output registers and grant_cnt.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=4'hF.
  - Required: gnt=0, rnd_valid=0, rnd_data=00 and grant_cnt=0 throughout reset.
  - After release, the first gnt=4'b0001 appears one cycle later.
- Sequence: req[0] held high with cfg_rate=8'h05.
  - rnd_data on successive cycles: 00, 01, 03, 07, 0E.
  - rnd_inject: 1, 1, 1, 0, 0.
- Round-robin: all four requests held high.
  - gnt: 0001, 0010, 0100, 1000, 0001.
  - Drop req[1] -> its turn is skipped: 0100 follows 0001.
- Seed load: cfg_seed=8'h1C strobed together with req[2].
  - No grant on the next cycle.
  - Then gnt=0100 with rnd_data=1C, followed by 39.
- Lockup guard: load seed 8'hFF -> next delivered rnd_data=00, then 01.
- Counter and reset mid-stream: after 65536 grants, grant_cnt=0.
  - Assert rst_n=0 during a grant burst -> all outputs return to reset values on that edge.
